// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and types.
//   AES_NR / AES_NK : round count and key length in words for AES-128
//   RCON            : round constants, indexed by expansion round 1..10
//   aes_word_t / aes_block_t : 32-bit word and 128-bit block
//   ks_state_t      : key-schedule FSM states
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-range rounds (0, 11..15) give 0 so the lookup is always safe
  // to evaluate even while the FSM is not expanding.
  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    aes_rcon = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) aes_rcon = RCON[r];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
//   in_i  : input byte
//   out_o : S-box substitution of in_i
// Computed as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the
// FIPS-197 affine transform, rather than a 256-entry table.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    gf_inv = acc;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv   = gf_inv(in_i);
    out_o = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_word.sv
// aes_sub_word: SubWord, one aes_sbox per byte lane.
//   w_i : input word (byte 0 in [31:24])
//   w_o : byte-wise S-box of w_i
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t w_i,
  output aes_word_t w_o
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [NUM_LANES-1:0][VEC_W-1:0] in_b;
  logic [NUM_LANES-1:0][VEC_W-1:0] out_b;

  assign in_b = w_i;
  assign w_o  = out_b;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .in_i  (in_b[g]),
      .out_o (out_b[g])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule, one round key per clock.
//   clk, rst_n  : clock, async active-low reset
//   start       : request expansion of key_in (accepted in IDLE/DONE only)
//   key_in      : cipher key, sampled on the accepting edge
//   busy        : expansion in progress
//   done        : one-cycle pulse after rk[10] is written
//   keys_valid  : all 11 round keys valid and stable
//   rd_idx      : round key index to read (11..15 read as 0)
//   rd_key      : registered read data, one cycle after rd_idx
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int RK_W       = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [RK_W-1:0] key_in,
  output logic            busy,
  output logic            done,
  output logic            keys_valid,
  input  logic [3:0]      rd_idx,
  output logic [RK_W-1:0] rd_key
);

  if (NUM_ROUNDS != AES_NR || RK_W != 128) begin : g_bad_cfg
    $error("aes_key_expand supports only NUM_ROUNDS=10, RK_W=128");
  end

  ks_state_t  state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       kv_q, kv_d;
  logic [RK_W-1:0] rd_key_q, rd_key_d;
  aes_block_t rk_q [0:NUM_ROUNDS];

  logic       ld_key;
  logic       wr_rk;

  // Previous round key; guard round 0 so the index never underflows.
  logic [3:0] prev_idx;
  aes_block_t prev;
  aes_word_t  w0, w1, w2, w3;
  aes_word_t  rot, sub, t;
  aes_word_t  n0, n1, n2, n3;
  aes_block_t new_rk;

  assign prev_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
  assign prev     = rk_q[prev_idx];
  assign w0       = prev[127:96];
  assign w1       = prev[95:64];
  assign w2       = prev[63:32];
  assign w3       = prev[31:0];
  assign rot      = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .w_i (rot),
    .w_o (sub)
  );

  assign t      = sub ^ {aes_rcon(round_q), 24'h0};
  assign n0     = w0 ^ t;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign new_rk = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    ld_key  = 1'b0;
    wr_rk   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ld_key  = 1'b1;
          round_d = 4'd1;
          state_d = EXPAND;
          busy_d  = 1'b1;
          kv_d    = 1'b0;
        end
      end
      EXPAND: begin
        wr_rk = 1'b1;
        if (round_q == 4'(NUM_ROUNDS)) begin
          // round stays at its final value; it never wraps.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_key_d = '0;
    if (rd_idx <= 4'(NUM_ROUNDS)) rd_key_d = rk_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      round_q  <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kv_q     <= 1'b0;
      rd_key_q <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      kv_q     <= kv_d;
      rd_key_q <= rd_key_d;
      if (ld_key) rk_q[0]       <= key_in;
      if (wr_rk)  rk_q[round_q] <= new_rk;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rd_idx = 4'd0;
  logic         busy, done, keys_valid;
  logic [127:0] rd_key;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int dcnt   = 0;
  int cyc    = 0;
  int kvlow  = 0;

  localparam logic [127:0] A1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand #(.NUM_ROUNDS(10), .RK_W(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // tick and count done pulses seen
  task automatic tick_c;
    tick();
    if (done) dcnt++;
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_kv",   128'(keys_valid), 128'd0);
    chk("rst_rdkey", rd_key, 128'd0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 A.1
    key_in = A1[0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("a1_busy", 128'(busy), 128'd1);
    cyc = 0;
    while (!done && cyc < 20) begin tick(); cyc++; end
    chk("a1_latency", 128'(cyc), 128'd10);
    chk("a1_kv", 128'(keys_valid), 128'd1);
    chk("a1_busy_end", 128'(busy), 128'd0);
    tick();
    chk("a1_done_pulse", 128'(done), 128'd0);
    rd_idx = 4'd1;  tick(); chk("a1_rk1", rd_key, A1[1]);
    rd_idx = 4'd10; tick(); chk("a1_rk10", rd_key, A1[10]);
    rd_idx = 4'd0;  tick(); chk("a1_rk0", rd_key, A1[0]);

    // re-key from DONE with all-zero key
    key_in = '0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    kvlow  = keys_valid ? 0 : 1;
    cyc    = 0;
    while (!done && cyc < 20) begin
      tick(); cyc++;
      if (!keys_valid) kvlow++;
    end
    chk("z_latency", 128'(cyc), 128'd10);
    chk("z_kv_low_cycles", 128'(kvlow), 128'd10);
    rd_idx = 4'd1;  tick(); chk("z_rk1", rd_key, Z1);
    rd_idx = 4'd10; tick(); chk("z_rk10", rd_key, Z10);
    repeat (3) tick();
    chk("z_kv_stays", 128'(keys_valid), 128'd1);

    // start pulses during EXPAND are ignored
    dcnt   = 0;
    key_in = A1[0];
    start  = 1'b1;
    tick_c();
    start  = 1'b0;
    tick_c();
    tick_c();
    key_in = '0;
    start  = 1'b1;
    tick_c();
    start  = 1'b0;
    repeat (3) tick_c();
    start  = 1'b1;
    tick_c();
    start  = 1'b0;
    repeat (8) tick_c();
    chk("ign_done_count", 128'(dcnt), 128'd1);
    chk("ign_kv", 128'(keys_valid), 128'd1);
    rd_idx = 4'd1;  tick(); chk("ign_rk1", rd_key, A1[1]);
    rd_idx = 4'd10; tick(); chk("ign_rk10", rd_key, A1[10]);

    // read sweep in DONE
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      chk($sformatf("sweep_%0d", i), rd_key, (i <= 10) ? A1[i] : 128'd0);
    end

    // async reset mid-expansion
    rd_idx = 4'd0;
    key_in = A1[0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    chk("mid_busy_pre", 128'(busy), 128'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    chk("mid_rst_kv",   128'(keys_valid), 128'd0);
    chk("mid_rst_rdkey", rd_key, 128'd0);
    #2;
    rst_n = 1'b1;
    dcnt  = 0;
    repeat (12) tick_c();
    chk("post_rst_no_done", 128'(dcnt), 128'd0);
    chk("post_rst_busy", 128'(busy), 128'd0);
    rd_idx = 4'd1;  tick(); chk("post_rst_rk1", rd_key, 128'd0);
    rd_idx = 4'd10; tick(); chk("post_rst_rk10", rd_key, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
